// File: rtl/fetch_pkg.sv
// Shared types and defaults for the per-PE instruction fetch front end.
package fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam int unsigned RESET_PC_DEF = 0;
  localparam int unsigned PC_STEP_DEF = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lane_state_e;

  // LSB of lane `lane` inside a packed NUM_PE*xlen bus.
  function automatic int lane_lsb(input int lane, input int xlen);
    return lane * xlen;
  endfunction

endpackage

// File: rtl/fetch_lane.sv
// One fetch lane: IDLE/RUN control, program counter, one-cycle return stage
// and a small instruction buffer drained over a valid/ready handshake.
module fetch_lane
  import fetch_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] PC_STEP    = XLEN'(PC_STEP_DEF),
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_read_enable,
  output logic [XLEN-1:0] imem_pc,
  input  logic [XLEN-1:0] imem_instruction,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lane_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] instr_buf [FIFO_DEPTH];
  logic [XLEN-1:0] pc_buf    [FIFO_DEPTH];
  logic            flush, push, pop;
  logic [CNT_W:0]  used;

  // Credits count buffered entries plus the one read that may be returning;
  // both come from registers so the read enable never sees an input.
  assign used             = {1'b0, count_q} + {{CNT_W{1'b0}}, vld_p1};
  assign imem_read_enable = (state_q == RUN) && (used < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_pc          = pc_q;

  assign flush    = redirect_valid && (state_q == RUN);
  assign if_valid = (count_q != '0);
  assign push     = vld_p1 && !flush;
  assign pop      = if_valid && if_ready && !flush;
  assign if_instr = if_valid ? instr_buf[rd_ptr_q] : '0;
  assign if_pc    = if_valid ? pc_buf[rd_ptr_q] : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((start || redirect_valid) && !halt) state_d = RUN;
      RUN:     if (halt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      vld_p1   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid)        pc_q <= redirect_pc;
      else if (imem_read_enable) pc_q <= pc_q + PC_STEP;
      // A read issued in the redirect cycle is wrong-path: never tracked.
      vld_p1 <= imem_read_enable && !flush;
      if (flush) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Return stage p1: request PC meets the instruction memory response
  always_ff @(posedge clk) begin
    pc_p1 <= pc_q;
    if (push) begin
      instr_buf[wr_ptr_q] <= imem_instruction;
      pc_buf[wr_ptr_q]    <= pc_p1;
    end
  end

endmodule

// File: rtl/pe_fetch_unit.sv
// Instruction fetch front end for the PE array: one independent fetch_lane
// per PE, with the packed instruction_memory buses sliced per lane.
module pe_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              NUM_PE     = 4,
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] PC_STEP    = XLEN'(PC_STEP_DEF),
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PE-1:0]      start,
  input  logic [NUM_PE-1:0]      halt,
  input  logic [NUM_PE-1:0]      redirect_valid,
  input  logic [NUM_PE*XLEN-1:0] redirect_pc,
  output logic [NUM_PE-1:0]      imem_read_enable,
  output logic [NUM_PE*XLEN-1:0] imem_pc,
  input  logic [NUM_PE*XLEN-1:0] imem_instruction,
  output logic [NUM_PE-1:0]      if_valid,
  input  logic [NUM_PE-1:0]      if_ready,
  output logic [NUM_PE*XLEN-1:0] if_instr,
  output logic [NUM_PE*XLEN-1:0] if_pc
);

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    localparam int LSB = lane_lsb(i, XLEN);

    fetch_lane #(
      .XLEN       (XLEN),
      .RESET_PC   (RESET_PC),
      .PC_STEP    (PC_STEP),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_lane (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start[i]),
      .halt             (halt[i]),
      .redirect_valid   (redirect_valid[i]),
      .redirect_pc      (redirect_pc[LSB +: XLEN]),
      .imem_read_enable (imem_read_enable[i]),
      .imem_pc          (imem_pc[LSB +: XLEN]),
      .imem_instruction (imem_instruction[LSB +: XLEN]),
      .if_valid         (if_valid[i]),
      .if_ready         (if_ready[i]),
      .if_instr         (if_instr[LSB +: XLEN]),
      .if_pc            (if_pc[LSB +: XLEN])
    );
  end

endmodule

// File: tb/tb_pe_fetch_unit.sv
// Self-checking bench for pe_fetch_unit: directed scenarios plus random
// start/halt/redirect/ready traffic against a per-lane queue reference model.
module tb_pe_fetch_unit;

  localparam int NUM_PE = 4;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_PE-1:0]      start, halt, redirect_valid, if_ready;
  logic [NUM_PE-1:0]      imem_read_enable, if_valid;
  logic [NUM_PE*XLEN-1:0] redirect_pc, imem_pc, imem_instruction, if_instr, if_pc;

  pe_fetch_unit #(
    .NUM_PE(NUM_PE), .XLEN(XLEN), .RESET_PC(32'h0), .PC_STEP(32'h1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_read_enable(imem_read_enable), .imem_pc(imem_pc),
    .imem_instruction(imem_instruction), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  function automatic logic [31:0] sl(input logic [NUM_PE*XLEN-1:0] b, input int i);
    return b[i*XLEN +: XLEN];
  endfunction

  // Instruction memory: word returned the cycle after the request, junk otherwise.
  always @(posedge clk)
    for (int i = 0; i < NUM_PE; i++)
      imem_instruction[i*XLEN +: XLEN] <= imem_read_enable[i] ?
        mem_word(imem_pc[i*XLEN +: XLEN]) : $urandom;

  typedef struct {
    logic [31:0] pc;
    int          t;
  } ent_t;

  ent_t        q [NUM_PE][$];
  logic [31:0] deliv [NUM_PE][$];
  bit          m_run [NUM_PE];
  logic [31:0] m_issue [NUM_PE];
  bit          hold [NUM_PE];
  logic [31:0] hold_instr [NUM_PE];
  logic [31:0] hold_pc [NUM_PE];
  int          obs_reads [NUM_PE];
  int          first_v [NUM_PE];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: every tracked read becomes deliverable two cycles after
  // issue, in order; a lane may hold at most DEPTH outstanding reads.
  task automatic monitor();
    for (int i = 0; i < NUM_PE; i++) begin
      logic        o_re, o_v, exp_re, exp_v, flush, xfer;
      logic [31:0] o_ipc, o_ins, o_pc;
      if (!rst_n) begin
        q[i].delete();
        m_run[i]   = 1'b0;
        m_issue[i] = 32'h0;
        hold[i]    = 1'b0;
        continue;
      end
      o_re  = imem_read_enable[i];
      o_v   = if_valid[i];
      o_ipc = sl(imem_pc, i);
      o_ins = sl(if_instr, i);
      o_pc  = sl(if_pc, i);
      if (o_re) obs_reads[i]++;
      if (o_v && first_v[i] < 0) first_v[i] = cyc;
      exp_re = m_run[i] && (q[i].size() < DEPTH);
      exp_v  = (q[i].size() > 0) && (q[i][0].t <= cyc);
      check_eq($sformatf("read_en[%0d]", i), 32'(o_re), 32'(exp_re));
      if (o_re && exp_re) check_eq($sformatf("read_pc[%0d]", i), o_ipc, m_issue[i]);
      check_eq($sformatf("if_valid[%0d]", i), 32'(o_v), 32'(exp_v));
      if (o_v && exp_v) begin
        check_eq($sformatf("if_pc[%0d]", i), o_pc, q[i][0].pc);
        check_eq($sformatf("if_instr[%0d]", i), o_ins, mem_word(q[i][0].pc));
      end
      if (hold[i]) begin
        check_eq($sformatf("hold_valid[%0d]", i), 32'(o_v), 32'd1);
        check_eq($sformatf("hold_instr[%0d]", i), o_ins, hold_instr[i]);
        check_eq($sformatf("hold_pc[%0d]", i), o_pc, hold_pc[i]);
      end
      flush         = redirect_valid[i] && m_run[i];
      xfer          = o_v && if_ready[i] && !flush;
      hold[i]       = o_v && !if_ready[i] && !flush;
      hold_instr[i] = o_ins;
      hold_pc[i]    = o_pc;
      if (flush) q[i].delete();
      else begin
        if (xfer && q[i].size() > 0) begin
          deliv[i].push_back(q[i][0].pc);
          void'(q[i].pop_front());
        end
        if (exp_re) q[i].push_back('{pc: m_issue[i], t: cyc + 2});
      end
      if (redirect_valid[i])  m_issue[i] = sl(redirect_pc, i);
      else if (exp_re)        m_issue[i] = m_issue[i] + 32'd1;
      if (m_run[i]) m_run[i] = !halt[i];
      else          m_run[i] = (start[i] || redirect_valid[i]) && !halt[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = '0; halt = '0; redirect_valid = '0;
    repeat (3) tick();
    for (int i = 0; i < NUM_PE; i++) begin
      check_eq($sformatf("rst_read_en[%0d]", i), 32'(imem_read_enable[i]), 32'd0);
      check_eq($sformatf("rst_imem_pc[%0d]", i), sl(imem_pc, i), 32'h0);
      check_eq($sformatf("rst_if_valid[%0d]", i), 32'(if_valid[i]), 32'd0);
      check_eq($sformatf("rst_if_instr[%0d]", i), sl(if_instr, i), 32'h0);
      check_eq($sformatf("rst_if_pc[%0d]", i), sl(if_pc, i), 32'h0);
      deliv[i].delete();
      obs_reads[i] = 0;
      first_v[i]   = -1;
    end
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] at(input int lane, input int k);
    return (deliv[lane].size() > k) ? deliv[lane][k] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int s_cyc, n0, r0, d;
    bit ok, any_v;
    logic [31:0] tgt;
    start = '0; halt = '0; redirect_valid = '0; redirect_pc = '0; if_ready = '0;

    // Reset and idle
    do_reset();
    repeat (10) tick();
    check_eq("idle_reads", 32'(obs_reads[0] + obs_reads[1] + obs_reads[2] + obs_reads[3]), 32'd0);

    // Streaming on all lanes
    if_ready = '1;
    start = '1; s_cyc = cyc;
    tick();
    start = '0;
    repeat (5) tick();
    for (int i = 0; i < NUM_PE; i++)
      check_eq($sformatf("first_valid_lat[%0d]", i), 32'(first_v[i] - s_cyc), 32'd3);
    n0 = deliv[0].size();
    repeat (16) tick();
    check_eq("throughput", 32'(deliv[0].size() - n0), 32'd16);
    for (int i = 0; i < NUM_PE; i++)
      for (int k = 0; k < 4; k++)
        check_eq($sformatf("stream_pc[%0d][%0d]", i, k), at(i, k), 32'(k));

    // Backpressure on lane 1
    if_ready[1] = 1'b0;
    r0 = obs_reads[1];
    repeat (8) tick();
    check_eq("bp_reads_le_depth", 32'((obs_reads[1] - r0) <= DEPTH), 32'd1);
    check_eq("bp_valid_held", 32'(if_valid[1]), 32'd1);
    if_ready[1] = 1'b1;
    repeat (10) tick();
    ok = 1'b1;
    foreach (deliv[1][k]) if (deliv[1][k] !== 32'(k)) ok = 1'b0;
    check_eq("bp_in_order", 32'(ok), 32'd1);

    // Redirect lane 3 with reads in flight
    d = deliv[3].size();
    redirect_valid[3] = 1'b1;
    redirect_pc[3*XLEN +: XLEN] = 32'h20;
    tick();
    redirect_valid = '0;
    repeat (6) tick();
    check_eq("redir_first", at(3, d), 32'h20);
    check_eq("redir_second", at(3, d + 1), 32'h21);

    // Reset mid-operation discards everything
    do_reset();
    any_v = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      any_v |= |if_valid;
    end
    check_eq("rst_mid_no_valid", 32'(any_v), 32'd0);

    // Halt lane 0 after 5 reads, lane 2 keeps running
    if_ready = '1;
    start = 4'b0101;
    tick();
    start = '0;
    repeat (4) tick();
    halt[0] = 1'b1;
    tick();
    halt = '0;
    repeat (12) tick();
    check_eq("halt_reads", 32'(obs_reads[0]), 32'd5);
    check_eq("halt_delivered", 32'(deliv[0].size()), 32'd5);
    check_eq("halt_idle", 32'(imem_read_enable[0]), 32'd0);
    check_eq("lane2_continues", 32'(deliv[2].size() >= 10), 32'd1);

    // PC wrap on lane 2
    d = deliv[2].size();
    redirect_valid[2] = 1'b1;
    redirect_pc[2*XLEN +: XLEN] = 32'hFFFF_FFFF;
    tick();
    redirect_valid = '0;
    repeat (6) tick();
    check_eq("wrap_first", at(2, d), 32'hFFFF_FFFF);
    check_eq("wrap_second", at(2, d + 1), 32'h0);

    // Redirect + halt in the same cycle
    redirect_valid[2] = 1'b1; halt[2] = 1'b1;
    redirect_pc[2*XLEN +: XLEN] = 32'h1234;
    tick();
    redirect_valid = '0; halt = '0;
    check_eq("rh_flushed", 32'(if_valid[2]), 32'd0);
    repeat (3) tick();
    check_eq("rh_idle", 32'(imem_read_enable[2]), 32'd0);
    start[2] = 1'b1;
    tick();
    start = '0;
    check_eq("rh_restart_en", 32'(imem_read_enable[2]), 32'd1);
    check_eq("rh_restart_pc", sl(imem_pc, 2), 32'h1234);

    // Random traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NUM_PE; i++) begin
        if_ready[i]       = ($urandom_range(0, 3) != 0);
        start[i]          = ($urandom_range(0, 15) == 0);
        halt[i]           = ($urandom_range(0, 39) == 0);
        redirect_valid[i] = ($urandom_range(0, 29) == 0);
        case ($urandom_range(0, 2))
          0:       tgt = $urandom;
          1:       tgt = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
          default: tgt = 32'($urandom_range(0, 255));
        endcase
        redirect_pc[i*XLEN +: XLEN] = tgt;
      end
      tick();
    end
    start = '0; halt = '0; redirect_valid = '0; if_ready = '1;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
